branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Parametrised dynamic branch predictor for the pipelined RV32 core. It replaces the fixed "PC+4, not-taken" fetch predictor.
- Fetch stage: combinational lookup of a direct-mapped BTB plus 2-bit saturating counters; produces the predicted next PC and the taken flag carried down the pipe.
- Execute stage: resolution writes the outcome back.
- Supports a bimodal mode and a gshare mode, and keeps branch/mispredict performance counters.

Parameters:
XLEN, 32, address/data width
ENTRIES, 16, BTB/PHT entries; power of two, 4..256
IDX_W, $clog2(ENTRIES), index width (derived, not overridden)
MODE, 0, 0 = bimodal (index = PC bits), 1 = gshare (index = PC bits XOR GHR)
GHR_W, IDX_W, global history length, used only when MODE=1; must be <= IDX_W
PERF_W, 32, width of the performance counters

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
fetch_pc  in  XLEN  PC currently being fetched
pred_taken  out  1  predicted taken (becomes the pipeline TAKENFLAG)
pred_next  out  XLEN  predicted next fetch PC
pred_index  out  IDX_W  table index used for this prediction; the pipeline carries it to execute
stall  in  1  pipeline stall; blocks all state updates
upd_valid  in  1  a control-transfer instruction resolved in execute this cycle
upd_index  in  IDX_W  pred_index returned from the resolving instruction
upd_pc  in  XLEN  PC of the resolving instruction
upd_is_cond  in  1  1 = conditional branch, 0 = unconditional jump (JAL/JALR)
upd_taken  in  1  actual outcome
upd_target  in  XLEN  actual target
upd_mispredict  in  1  resolved outcome or target differed from the prediction
perf_branches  out  PERF_W  resolved control transfers
perf_mispredicts  out  PERF_W  mispredictions

Behaviour:
Reset and address fields
- reset is asynchronous and active-high.
- On reset: all valid bits = 0, all counters = 2'b01 (weakly not-taken), GHR = 0, perf counters = 0.
- While no entry hits (including out of reset): pred_taken = 0 and pred_next = fetch_pc + 4.
- Tag = fetch_pc[XLEN-1:IDX_W+2]. PC bits [1:0] are ignored.
- MODE=0: index = fetch_pc[IDX_W+1:2].
- MODE=1: index = fetch_pc[IDX_W+1:2] XOR zero-extended GHR.

Lookup (zero latency, purely combinational from fetch_pc and current table state)
- hit = valid[idx] & (tag[idx] == fetch tag).
- pred_taken = hit & (jump[idx] | ctr[idx][1]).
- pred_next = pred_taken ? target[idx] : fetch_pc + 4. The addition wraps modulo 2^XLEN.

Update (at posedge clk, only when upd_valid & ~stall; the table is addressed by upd_index)
- Hit (tag matches upd_pc):
  - Conditional entry: counter saturating +1 if taken, -1 if not taken (00 floor, 11 ceiling).
  - If taken: target <= upd_target.
  - Jump entry: counter unchanged.
- Miss, taken: allocate/overwrite the entry. valid = 1, tag from upd_pc, target = upd_target, jump = ~upd_is_cond, counter = 2'b10.
- Miss, not taken: no table change.
- GHR (MODE=1 only, upd_is_cond only): shift left, inserting upd_taken at bit 0. GHR is non-speculative.

Performance counters
- perf_branches +1 on every accepted update.
- perf_mispredicts +1 when upd_mispredict is also high.
- Both saturate at all-ones and never wrap.

Simultaneous events
- Lookup and update in the same cycle, same index: lookup returns the pre-update contents; the new state is visible the next cycle.
- stall high: tables, GHR and perf counters hold. Lookup outputs still track fetch_pc.
- reset asserted mid-update overrides the update; state is cleared immediately, without waiting for a clock edge.

Decomposition:
Package bp_pkg holds:
- counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
- the reset counter value WNT and the allocate value WT;
- the entry field layout: valid, jump, ctr[1:0], tag, target.

Sub-module bp_sat_ctr is a 2-bit saturating next-state block (inputs ctr, taken; output ctr_next), instanced once on the update path. Table storage is register arrays, so reset clears them asynchronously.

Test Plan:
1. Reset, then fetch_pc=0x100 -> pred_taken=0, pred_next=0x104, perf_branches=0, perf_mispredicts=0.
2. MODE=0. Update pc=0x100, cond, taken, target 0x80, mispredict=1; next cycle fetch 0x100 -> pred_taken=1, pred_next=0x80, perf_mispredicts=1.
3. Counter saturation: from case 2 (ctr=WT), 3 not-taken updates drive ctr to 00; a 4th not-taken keeps 00 and the lookup stays not-taken. Then 2 taken updates reach WT and the lookup predicts taken again.
4. Aliasing, ENTRIES=16: allocate pc=0x100 taken, then fetch 0x140 (same index, different tag) -> miss, pred_next=0x144. Then a taken update at 0x140 replaces the entry; fetch 0x100 now misses.
5. Jump and same-cycle update: JAL pc=0x200, target 0x400 allocated -> always taken even after a not-taken update. An update and a lookup at index 0 in the same cycle -> the lookup shows the old value and the new value appears next cycle.
6. stall=1 with upd_valid=1 -> no table, GHR or perf change. MODE=1: two taken cond updates -> GHR=2'b11; fetch_pc=0x100 indexes (0x40 XOR 3) & 0xF = 3.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared encodings and entry layout for the BTB/PHT branch predictor.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] CTR_RESET = WNT;
  localparam logic [1:0] CTR_ALLOC = WT;

  // Per-entry control fields; tag and target widths depend on module parameters,
  // so they live in separate arrays alongside this struct.
  typedef struct packed {
    logic       valid;
    logic       jump;
    logic [1:0] ctr;
  } bp_meta_t;

  localparam bp_meta_t META_RESET = '{valid: 1'b0, jump: 1'b0, ctr: CTR_RESET};

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter next-state: step toward ST when taken, toward SNT otherwise.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters; combinational fetch lookup, execute-stage update,
// optional gshare indexing and saturating performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned  XLEN    = 32,
  parameter int unsigned  ENTRIES = 16,
  localparam int unsigned IDX_W   = $clog2(ENTRIES),
  parameter int unsigned  MODE    = 0,
  parameter int unsigned  GHR_W   = IDX_W,
  parameter int unsigned  PERF_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   fetch_pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_next,
  output logic [IDX_W-1:0]  pred_index,
  input  logic              stall,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_index,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_is_cond,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_mispredict,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  bp_meta_t              meta_q   [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [XLEN-1:0]       target_q [ENTRIES];
  logic [GHR_W-1:0]      ghr_q;
  logic [PERF_W-1:0]     branches_q;
  logic [PERF_W-1:0]     mispredicts_q;

  logic [IDX_W-1:0]      ghr_ext;
  logic [IDX_W-1:0]      fetch_idx;
  logic [TAG_W-1:0]      fetch_tag;
  logic                  fetch_hit;
  bp_meta_t              fetch_meta;

  logic [TAG_W-1:0]      upd_tag;
  bp_meta_t              upd_meta;
  logic                  upd_hit;
  logic                  accept;
  logic [1:0]            ctr_next;

  // Low PC bits of the resolving instruction are implied by upd_index.
  logic                  unused_upd_bits;
  assign unused_upd_bits = ^upd_pc[IDX_W+1:0];

  always_comb begin
    ghr_ext = '0;
    ghr_ext[GHR_W-1:0] = ghr_q;
  end

  // Fetch-side lookup
  always_comb begin
    fetch_idx  = fetch_pc[IDX_W+1:2] ^ ((MODE == 1) ? ghr_ext : '0);
    fetch_tag  = fetch_pc[XLEN-1:IDX_W+2];
    fetch_meta = meta_q[fetch_idx];
    fetch_hit  = fetch_meta.valid && (tag_q[fetch_idx] == fetch_tag);
    pred_taken = fetch_hit && (fetch_meta.jump || fetch_meta.ctr[1]);
    pred_next  = pred_taken ? target_q[fetch_idx] : fetch_pc + XLEN'(4);
    pred_index = fetch_idx;
  end

  // Execute-side resolution
  always_comb begin
    accept   = upd_valid && !stall;
    upd_tag  = upd_pc[XLEN-1:IDX_W+2];
    upd_meta = meta_q[upd_index];
    upd_hit  = upd_meta.valid && (tag_q[upd_index] == upd_tag);
  end

  bp_sat_ctr u_sat_ctr (
    .ctr      (upd_meta.ctr),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        meta_q[i]   <= META_RESET;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (accept) begin
      if (upd_hit) begin
        if (!upd_meta.jump) meta_q[upd_index].ctr <= ctr_next;
        if (upd_taken) target_q[upd_index] <= upd_target;
      end else if (upd_taken) begin
        meta_q[upd_index]   <= '{valid: 1'b1, jump: !upd_is_cond, ctr: CTR_ALLOC};
        tag_q[upd_index]    <= upd_tag;
        target_q[upd_index] <= upd_target;
      end
    end
  end

  // Non-speculative history: only resolved conditional branches shift in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (accept && upd_is_cond && (MODE == 1)) begin
      ghr_q <= (ghr_q << 1) | GHR_W'(upd_taken);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (accept) begin
      if (branches_q != '1) branches_q <= branches_q + PERF_W'(1);
      if (upd_mispredict && (mispredicts_q != '1)) mispredicts_q <= mispredicts_q + PERF_W'(1);
    end
  end

  assign perf_branches    = branches_q;
  assign perf_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: bimodal instance for table behaviour, gshare for indexing.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        stall;
  logic        upd_valid;
  logic [3:0]  upd_index;
  logic [31:0] upd_pc;
  logic        upd_is_cond;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;

  logic        pred_taken,   pred_taken_g;
  logic [31:0] pred_next,    pred_next_g;
  logic [3:0]  pred_index,   pred_index_g;
  logic [31:0] perf_br,      perf_br_g;
  logic [31:0] perf_mp,      perf_mp_g;

  int total = 0;
  int bad   = 0;
  int br    = 0;
  int mp    = 0;

  typedef struct {
    string       tag;
    logic        tk;
    logic [31:0] nx;
    logic [3:0]  idx;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .MODE(0), .PERF_W(32)) dut (
    .clk (clk), .reset (reset), .fetch_pc (fetch_pc),
    .pred_taken (pred_taken), .pred_next (pred_next), .pred_index (pred_index),
    .stall (stall), .upd_valid (upd_valid), .upd_index (upd_index), .upd_pc (upd_pc),
    .upd_is_cond (upd_is_cond), .upd_taken (upd_taken), .upd_target (upd_target),
    .upd_mispredict (upd_mispredict), .perf_branches (perf_br), .perf_mispredicts (perf_mp)
  );

  branch_predictor #(.XLEN(32), .ENTRIES(16), .MODE(1), .PERF_W(32)) dut_g (
    .clk (clk), .reset (reset), .fetch_pc (fetch_pc),
    .pred_taken (pred_taken_g), .pred_next (pred_next_g), .pred_index (pred_index_g),
    .stall (stall), .upd_valid (upd_valid), .upd_index (upd_index), .upd_pc (upd_pc),
    .upd_is_cond (upd_is_cond), .upd_taken (upd_taken), .upd_target (upd_target),
    .upd_mispredict (upd_mispredict), .perf_branches (perf_br_g), .perf_mispredicts (perf_mp_g)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Bimodal lookup: expectation queued when fetch_pc is driven, compared once outputs settle.
  task automatic look(input string tag, input logic [31:0] pc, input logic tk,
                      input logic [31:0] nx);
    exp_t e;
    fetch_pc = pc;
    e.tag = tag; e.tk = tk; e.nx = nx; e.idx = pc[5:2];
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    check({e.tag, "_taken"}, {31'b0, pred_taken}, {31'b0, e.tk});
    check({e.tag, "_next"},  pred_next, e.nx);
    check({e.tag, "_br"},    perf_br, br);
    check({e.tag, "_mp"},    perf_mp, mp);
  endtask

  task automatic look_g(input string tag, input logic [31:0] pc, input logic [3:0] idx);
    exp_t e;
    fetch_pc = pc;
    e.tag = tag; e.tk = 1'b0; e.nx = pc + 32'd4; e.idx = idx;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    check({e.tag, "_gidx"}, {28'b0, pred_index_g}, {28'b0, e.idx});
  endtask

  task automatic drive_upd(input logic [3:0] idx, input logic [31:0] pc, input logic cond,
                           input logic tk, input logic [31:0] tgt, input logic mis);
    upd_valid = 1'b1; upd_index = idx; upd_pc = pc; upd_is_cond = cond;
    upd_taken = tk; upd_target = tgt; upd_mispredict = mis;
  endtask

  task automatic do_upd(input logic [3:0] idx, input logic [31:0] pc, input logic cond,
                        input logic tk, input logic [31:0] tgt, input logic mis);
    drive_upd(idx, pc, cond, tk, tgt, mis);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    if (!stall) begin
      br++;
      if (mis) mp++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fetch_pc = '0; stall = 1'b0; upd_valid = 1'b0; upd_index = '0;
    upd_pc = '0; upd_is_cond = 1'b0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    #12 reset = 1'b0;
    @(posedge clk); #1;

    look("reset", 32'h100, 1'b0, 32'h104);
    check("reset_idx", {28'b0, pred_index}, 32'h0);

    do_upd(4'd0, 32'h100, 1'b1, 1'b1, 32'h80, 1'b1);
    look("alloc", 32'h100, 1'b1, 32'h80);

    // WT -> WNT -> SNT -> SNT -> SNT, then back up to WT
    do_upd(4'd0, 32'h100, 1'b1, 1'b0, 32'h0, 1'b1);
    look("nt1", 32'h100, 1'b0, 32'h104);
    for (int i = 0; i < 3; i++) do_upd(4'd0, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
    look("floor", 32'h100, 1'b0, 32'h104);
    do_upd(4'd0, 32'h100, 1'b1, 1'b1, 32'h80, 1'b1);
    look("t1", 32'h100, 1'b0, 32'h104);
    do_upd(4'd0, 32'h100, 1'b1, 1'b1, 32'h80, 1'b1);
    look("t2", 32'h100, 1'b1, 32'h80);

    look("alias_miss", 32'h140, 1'b0, 32'h144);
    do_upd(4'd0, 32'h140, 1'b1, 1'b1, 32'h300, 1'b1);
    look("alias_new", 32'h140, 1'b1, 32'h300);
    look("alias_old", 32'h100, 1'b0, 32'h104);

    do_upd(4'd0, 32'h200, 1'b0, 1'b1, 32'h400, 1'b1);
    look("jal", 32'h200, 1'b1, 32'h400);
    do_upd(4'd0, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
    look("jal_nt", 32'h200, 1'b1, 32'h400);

    drive_upd(4'd0, 32'h100, 1'b1, 1'b1, 32'h88, 1'b0);
    look("same_old", 32'h100, 1'b0, 32'h104);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    br++;
    look("same_new", 32'h100, 1'b1, 32'h88);

    stall = 1'b1;
    do_upd(4'd0, 32'h200, 1'b0, 1'b1, 32'h500, 1'b1);
    look("stall", 32'h200, 1'b0, 32'h204);
    look("stall_keep", 32'h100, 1'b1, 32'h88);
    stall = 1'b0;

    // Asynchronous reset mid-update, checked before any clock edge
    drive_upd(4'd0, 32'h300, 1'b1, 1'b1, 32'h900, 1'b1);
    reset = 1'b1;
    #1;
    br = 0; mp = 0;
    look("async_rst", 32'h100, 1'b0, 32'h104);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    reset = 1'b0;
    look("post_rst", 32'h300, 1'b0, 32'h304);

    look_g("g_reset", 32'h100, 4'd0);
    stall = 1'b1;
    do_upd(4'd0, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0);
    stall = 1'b0;
    look_g("g_stall", 32'h100, 4'd0);
    do_upd(4'd0, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0);
    look_g("g_one", 32'h100, 4'd1);
    do_upd(4'd0, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0);
    look_g("g_two", 32'h100, 4'd3);
    check("g_miss", {31'b0, pred_taken_g}, 32'h0);
    do_upd(4'd0, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0);
    look_g("g_nt", 32'h100, 4'd6);
    do_upd(4'd0, 32'h200, 1'b0, 1'b1, 32'h400, 1'b0);
    look_g("g_jal", 32'h100, 4'd6);
    check("g_br", perf_br_g, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
